multicycle_seq_ctrl: RTL
========================

Name: multicycle_seq_ctrl

Overview:
Multi-cycle sequencer for the RV32 datapath. Owns the PC and instruction register, fetches over a req/ack instruction-memory handshake, and decodes the opcode class. It steps the datapath through DECODE/EXEC/MEM/WB, issuing one-cycle register-write and memory strobes, and resolves branch/jump PC selection from datapath flags. It halts on ECALL/EBREAK, illegal opcode, misaligned target or bus timeout.

Parameters:
XLEN, 32, PC/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max wait cycles for any ack before error halt (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  leave IDLE and begin fetching (level, sampled in IDLE only)
imem_req  out  1  instruction fetch request, held until imem_ack
imem_addr  out  XLEN  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid same cycle
imem_rdata  in  32  fetched instruction
instr  out  32  latched instruction register driving datapath decode fields
br_taken  in  1  datapath branch condition (beq|bneq|bge|blt), valid in EXEC
jump  in  1  datapath jump indication, valid in EXEC
target  in  XLEN  branch/jump target, valid in EXEC
dmem_req  out  1  data access request, held until dmem_ack
dmem_we  out  1  1 = store, qualifies dmem_req
dmem_ack  in  1  data access complete
reg_we  out  1  register-file write strobe, exactly one cycle per retiring writer
pc  out  XLEN  current PC
state  out  3  encoded FSM state (debug)
halted  out  1  in HALT
err  out  2  00 none, 01 illegal opcode, 10 misaligned target, 11 timeout
retired  out  32  retired-instruction counter

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, instr=0, retired=0, err=00; all strobes and halted = 0.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: start=1 -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata -> DECODE.
- DECODE (1 cycle) classifies instr[6:0]:
  - LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, LUI 0110111, OP 0110011, OP-IMM 0010011 -> EXEC.
  - SYSTEM 1110011 -> HALT, err=00, retired+1.
  - Any other opcode -> HALT, err=01, not retired.
- EXEC (1 cycle):
  - LOAD/STORE -> MEM.
  - OP/OP-IMM/LUI/JAL -> WB.
  - BRANCH -> FETCH with pc update, retired+1.
- MEM: dmem_req=1, dmem_we=1 for STORE only. On dmem_ack: LOAD -> WB; STORE -> FETCH with pc update, retired+1.
- WB (1 cycle): reg_we=1, pc update, retired+1 -> FETCH.
- PC update: next = (jump | (BRANCH & br_taken)) ? target : pc+4, with br_taken/jump/target captured in EXEC.
  - If the selected target has [1:0] != 00 -> HALT, err=10; pc unchanged; instruction not retired; reg_we suppressed.
- pc+4 wraps modulo 2^XLEN silently. retired wraps at 2^32.
- Timeout: per-request wait counter cleared on entering FETCH/MEM, incremented each cycle without ack. Reaching TIMEOUT -> HALT, err=11, request dropped next cycle.
- Ack arriving in the same cycle the counter hits TIMEOUT: ack wins.
- Ack outside FETCH/MEM is ignored.
- HALT: sticky; halted=1; all strobes 0; only reset exits.
- Reset mid-transaction: req drops immediately (async), no reg_we/dmem_we glitch, pc=RESET_PC.
- imem_req/dmem_req never asserted together; reg_we never asserted with dmem_req.

Test Plan:
- Reset then start, imem_ack on first req cycle, instr=ADDI (0x00500093) -> reg_we high exactly in cycle 5 after start, pc=4, retired=1.
- LOAD 0x00002083 with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then a single reg_we, pc=4.
- BRANCH 0x00000463 with br_taken=1, target=0x40 -> pc=0x40, no reg_we. Repeat with br_taken=0 -> pc=4.
- JAL with target=0x42 -> HALT, err=10, pc unchanged, retired unchanged.
- imem_ack withheld with TIMEOUT=16 -> imem_req high 16 cycles, then HALT, err=11. Variant: ack exactly on the 16th cycle -> DECODE, no error.
- Opcode 0x7F -> HALT, err=01. ECALL 0x00000073 -> HALT, err=00, retired+1. Async rst pulse mid-MEM -> IDLE, pc=RESET_PC, dmem_req=0 at once.

Source files
------------

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle RV32 sequencer: owns PC/IR, fetches over a req/ack handshake and
// steps the datapath through DECODE/EXEC/MEM/WB, halting sticky on any fault.
module multicycle_seq_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  input  logic            br_taken,
  input  logic            jump,
  input  logic [XLEN-1:0] target,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            reg_we,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      state,
  output logic            halted,
  output logic [1:0]      err,
  output logic [31:0]     retired
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t          r_state,   w_state_nxt;
  logic [XLEN-1:0] r_pc,      w_pc_nxt;
  logic [XLEN-1:0] r_npc,     w_npc_nxt;
  logic [31:0]     r_instr,   w_instr_nxt;
  logic [31:0]     r_retired, w_retired_nxt;
  logic [1:0]      r_err,     w_err_nxt;
  logic [WW-1:0]   r_wait,    w_wait_nxt;

  logic [6:0]      w_opc;
  logic            w_is_branch;
  logic            w_is_store;
  logic            w_is_mem;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_sel_pc;
  logic            w_wait_last;
  logic            w_npc_ok;

  assign w_opc       = r_instr[6:0];
  assign w_is_branch = (w_opc == OPC_BRANCH);
  assign w_is_store  = (w_opc == OPC_STORE);
  assign w_is_mem    = (w_opc == OPC_LOAD) || w_is_store;
  assign w_pc_plus4  = r_pc + XLEN'(32'd4);
  // br_taken/jump/target are only meaningful in EXEC; everything later uses r_npc
  assign w_sel_pc    = (jump || (w_is_branch && br_taken)) ? target : w_pc_plus4;
  assign w_wait_last = (r_wait == WW'(TIMEOUT - 1));
  assign w_npc_ok    = (r_npc[1:0] == 2'b00);

  // State and datapath-control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_npc     <= RESET_PC;
      r_instr   <= 32'h0000_0000;
      r_retired <= 32'h0000_0000;
      r_err     <= ERR_NONE;
      r_wait    <= {WW{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_npc     <= w_npc_nxt;
      r_instr   <= w_instr_nxt;
      r_retired <= w_retired_nxt;
      r_err     <= w_err_nxt;
      r_wait    <= w_wait_nxt;
    end
  end

  // Next-state, PC selection, retire counting and fault classification
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_npc_nxt     = r_npc;
    w_instr_nxt   = r_instr;
    w_retired_nxt = r_retired;
    w_err_nxt     = r_err;
    w_wait_nxt    = r_wait;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_wait_nxt  = {WW{1'b0}};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_instr_nxt = imem_rdata;
          w_state_nxt = S_DECODE;
        end else if (w_wait_last) begin
          w_state_nxt = S_HALT;
          w_err_nxt   = ERR_TIMEOUT;
        end else begin
          w_wait_nxt  = r_wait + WW'(1);
        end
      end
      S_DECODE: begin
        case (w_opc)
          OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
          OPC_LUI, OPC_OP, OPC_OPIMM: w_state_nxt = S_EXEC;
          OPC_SYSTEM: begin
            w_state_nxt   = S_HALT;
            w_retired_nxt = r_retired + 32'd1;
          end
          default: begin
            w_state_nxt = S_HALT;
            w_err_nxt   = ERR_ILLEGAL;
          end
        endcase
      end
      S_EXEC: begin
        if (w_is_branch) begin
          if (w_sel_pc[1:0] == 2'b00) begin
            w_pc_nxt      = w_sel_pc;
            w_retired_nxt = r_retired + 32'd1;
            w_state_nxt   = S_FETCH;
            w_wait_nxt    = {WW{1'b0}};
          end else begin
            w_state_nxt = S_HALT;
            w_err_nxt   = ERR_ALIGN;
          end
        end else begin
          w_npc_nxt  = w_sel_pc;
          w_wait_nxt = {WW{1'b0}};
          if (w_is_mem) begin
            w_state_nxt = S_MEM;
          end else begin
            w_state_nxt = S_WB;
          end
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (!w_is_store) begin
            w_state_nxt = S_WB;
          end else if (w_npc_ok) begin
            w_pc_nxt      = r_npc;
            w_retired_nxt = r_retired + 32'd1;
            w_state_nxt   = S_FETCH;
            w_wait_nxt    = {WW{1'b0}};
          end else begin
            w_state_nxt = S_HALT;
            w_err_nxt   = ERR_ALIGN;
          end
        end else if (w_wait_last) begin
          w_state_nxt = S_HALT;
          w_err_nxt   = ERR_TIMEOUT;
        end else begin
          w_wait_nxt  = r_wait + WW'(1);
        end
      end
      S_WB: begin
        if (w_npc_ok) begin
          w_pc_nxt      = r_npc;
          w_retired_nxt = r_retired + 32'd1;
          w_state_nxt   = S_FETCH;
          w_wait_nxt    = {WW{1'b0}};
        end else begin
          w_state_nxt = S_HALT;
          w_err_nxt   = ERR_ALIGN;
        end
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_HALT;
    endcase
  end

  // Strobes decode straight from the state register so async reset drops them at once
  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign dmem_req  = (r_state == S_MEM);
  assign dmem_we   = (r_state == S_MEM) && w_is_store;
  assign reg_we    = (r_state == S_WB) && w_npc_ok;
  assign instr     = r_instr;
  assign pc        = r_pc;
  assign state     = r_state;
  assign halted    = (r_state == S_HALT);
  assign err       = r_err;
  assign retired   = r_retired;

endmodule
